// File: rtl/param_combined_memory_pkg.sv
// param_combined_memory_pkg: shared widths, FSM state encoding and depth helper
package param_combined_memory_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/param_ram_1w1r.sv
// param_ram_1w1r: synchronous-write RAM with registered read of pre-write contents
module param_ram_1w1r
    import param_combined_memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [depth_of(ADDR_W)];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/param_combined_memory.sv
// param_combined_memory: A/D registers plus forwarded RAM at A, with post-reset clear
module param_combined_memory
    import param_combined_memory_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              cl,
    input  logic              rst,
    input  logic              st_a,
    input  logic              st_d,
    input  logic              st_m,
    input  logic [DATA_W-1:0] X,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] M,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(depth_of(ADDR_W) - 1);
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              idle;
    logic [DATA_W-1:0] a_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] fwd_d;
    logic              fwd_q;
    logic              m_zero;
    always_comb begin
        idle  = state == ST_IDLE;
        busy  = !idle;
        a_n   = (idle && st_a) ? X : A;
        we    = !rst && (!idle || st_m);
        waddr = idle ? A[ADDR_W-1:0] : cnt;
        wdata = idle ? X : '0;
        M     = m_zero ? '0 : (fwd_q ? fwd_d : rdata);
    end
    param_ram_1w1r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk  (cl),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(a_n[ADDR_W-1:0]),
        .rdata(rdata)
    );
    // The RAM returns pre-write data, so a store to the address being read is forwarded here.
    always_ff @(posedge cl) begin
        if (rst) begin
            A      <= '0;
            D      <= '0;
            cnt    <= '0;
            state  <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            m_zero <= 1'b1;
            fwd_q  <= 1'b0;
        end else if (!idle) begin
            cnt    <= cnt + 1'b1;
            state  <= (cnt == LAST) ? ST_IDLE : ST_CLEAR;
            m_zero <= 1'b1;
        end else begin
            A      <= a_n;
            D      <= st_d ? X : D;
            fwd_q  <= st_m && (a_n[ADDR_W-1:0] == A[ADDR_W-1:0]);
            fwd_d  <= X;
            m_zero <= 1'b0;
        end
    end
endmodule

// File: tb/tb_param_combined_memory.sv
// tb_param_combined_memory: table, directed and randomized checks against a behavioural model
module tb_param_combined_memory;
    logic cl = 1'b0;
    logic rst, st_a, st_d, st_m;
    logic [15:0] x;
    logic [15:0] a_o [2];
    logic [15:0] d_o [2];
    logic [15:0] m_o [2];
    logic        busy_o [2];
    int checks = 0;
    int errors = 0;

    param_combined_memory #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut0 (
        .cl(cl), .rst(rst), .st_a(st_a), .st_d(st_d), .st_m(st_m), .X(x),
        .A(a_o[0]), .D(d_o[0]), .M(m_o[0]), .busy(busy_o[0])
    );
    param_combined_memory #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) dut1 (
        .cl(cl), .rst(rst), .st_a(st_a), .st_d(st_d), .st_m(st_m), .X(x),
        .A(a_o[1]), .D(d_o[1]), .M(m_o[1]), .busy(busy_o[1])
    );

    always #5 cl = ~cl;

    // Model: the RAM is a plain array; unknown words (never written since a non-clearing reset) are tracked.
    logic [15:0] mram [2][16];
    bit          mval [2][16];
    logic [15:0] ma [2];
    logic [15:0] md [2];
    logic [15:0] mm [2];
    bit          mk [2];
    int          left [2] = '{0, 0};

    task automatic model();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ma[k] = 0; md[k] = 0; mm[k] = 0; mk[k] = 1;
                left[k] = (k == 0) ? 16 : 0;
                if (k == 1) for (int i = 0; i < 16; i++) mval[1][i] = 0;
            end else if (left[k] > 0) begin
                left[k]--;
                if (left[k] == 0) for (int i = 0; i < 16; i++) begin mram[k][i] = 0; mval[k][i] = 1; end
            end else begin
                if (st_m) begin mram[k][ma[k][3:0]] = x; mval[k][ma[k][3:0]] = 1; end
                if (st_a) ma[k] = x;
                if (st_d) md[k] = x;
                mm[k] = mram[k][ma[k][3:0]];
                mk[k] = mval[k][ma[k][3:0]];
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cl);
        model();
        #1;
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(left[k] > 0));
            chk($sformatf("a%0d", k), 32'(a_o[k]), 32'(ma[k]));
            chk($sformatf("d%0d", k), 32'(d_o[k]), 32'(md[k]));
            if (mk[k]) chk($sformatf("m%0d", k), 32'(m_o[k]), 32'(mm[k]));
        end
    endtask

    task automatic clear_len(input string nm);
        int n = 0;
        while (busy_o[0] && n < 40) begin
            tick();
            model_check();
            chk("cor0_busy", 32'(busy_o[1]), 32'(0));
            n++;
        end
        chk(nm, n, 16);
    endtask

    typedef struct {
        logic sa, sd, sm;
        logic [15:0] x, ea, ed, em;
    } vec_t;
    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0003, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h0003, 16'h1234, 16'hBEEF};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005, 16'h1234, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h1234, 16'h0005};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'hFFF3, 16'hFFF3, 16'h1234, 16'h0005};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h00AA, 16'hFFF3, 16'h1234, 16'h00AA};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h1234, 16'h00AA};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 16'h0003, 16'h0003, 16'h0003, 16'h0003};

        rst = 1; st_a = 0; st_d = 0; st_m = 0; x = 0;
        tick();
        chk("rst_a", 32'(a_o[0]), 0);
        chk("rst_d", 32'(d_o[0]), 0);
        chk("rst_m", 32'(m_o[0]), 0);
        chk("rst_busy0", 32'(busy_o[0]), 1);
        chk("rst_busy1", 32'(busy_o[1]), 0);
        model_check();

        rst = 0; st_a = 1; st_d = 1; st_m = 1; x = 16'h7777;
        clear_len("clear_len");
        st_a = 0; st_d = 0; st_m = 0;
        chk("mask_a", 32'(a_o[0]), 0);
        chk("mask_d", 32'(d_o[0]), 0);
        chk("mask_m", 32'(m_o[0]), 0);

        for (int i = 0; i < 16; i++) begin
            st_a = 1; x = 16'(i);
            tick();
            chk($sformatf("zero_rd%0d", i), 32'(m_o[0]), 0);
            model_check();
        end

        for (int i = 0; i < 10; i++) begin
            st_a = tbl[i].sa; st_d = tbl[i].sd; st_m = tbl[i].sm; x = tbl[i].x;
            tick();
            chk($sformatf("tbl%0d_a", i), 32'(a_o[0]), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d_d", i), 32'(d_o[0]), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_m", i), 32'(m_o[0]), 32'(tbl[i].em));
            model_check();
        end

        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(63) == 0);
            st_a = 1'($urandom_range(1));
            st_d = 1'($urandom_range(1));
            st_m = 1'($urandom_range(1));
            x    = $urandom_range(1) ? 16'($urandom_range(15)) : 16'($urandom);
            tick();
            model_check();
        end

        rst = 1; st_a = 0; st_d = 0; st_m = 0;
        tick();
        rst = 0;
        repeat (6) begin tick(); model_check(); end
        rst = 1;
        tick();
        rst = 0;
        model_check();
        clear_len("restart_len");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
